// File: rtl/freq_track_ctrl.sv
// Frequency-acquisition controller: measures DCO cycles over a window of
// reference edges and steps the DCO code toward the target count.
module freq_track_ctrl #(
  parameter int CODE_BITS   = 8,
  parameter int COUNT_BITS  = 12,
  parameter int WIN_BITS    = 2,
  parameter int COARSE_STEP = 4,
  parameter int CODE_INIT   = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  refEdge,
  input  logic [COUNT_BITS-1:0] target,
  input  logic [2:0]            deadband,
  output logic                  freqUp,
  output logic                  freqDn,
  output logic [CODE_BITS-1:0]  freqCode,
  output logic                  tracking
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_COUNT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  localparam int CW = COUNT_BITS + 2;
  localparam logic [COUNT_BITS-1:0] CNT_MAX     = '1;
  localparam logic [WIN_BITS-1:0]   REF_LAST    = '1;
  localparam logic [CODE_BITS-1:0]  CODE_MAX    = '1;
  localparam logic [CODE_BITS-1:0]  CODE_RST    = CODE_BITS'(CODE_INIT);
  localparam logic [CODE_BITS:0]    STEP_ONE    = (CODE_BITS+1)'(1);
  localparam logic [CODE_BITS:0]    STEP_COARSE = (CODE_BITS+1)'(COARSE_STEP);

  state_t                state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [COUNT_BITS-1:0] dco_cnt_q, dco_cnt_d;
  logic [WIN_BITS-1:0]   ref_cnt_q, ref_cnt_d;
  logic [CODE_BITS-1:0]  code_q, code_d;
  logic                  up_q, up_d;
  logic                  dn_q, dn_d;
  logic                  tracking_q, tracking_d;

  logic [COUNT_BITS-1:0] dco_inc;
  logic [CW-1:0]         meas_ext, tgt_ext, db_ext, lo_ext, hi_ext;
  logic                  slow, fast, rev_up, rev_dn;
  logic [CODE_BITS:0]    step_up, step_dn, up_sum;
  logic [CODE_BITS-1:0]  code_up, code_dn;

  // The measurement is sat(dco_cnt+1) at the closing edge, which is the same
  // value the saturating counter would hold next cycle.
  always_comb begin
    dco_inc  = (dco_cnt_q == CNT_MAX) ? CNT_MAX : dco_cnt_q + 1'b1;
    meas_ext = CW'(dco_inc);
    tgt_ext  = CW'(target);
    db_ext   = CW'(deadband);
    lo_ext   = (tgt_ext < db_ext) ? '0 : tgt_ext - db_ext;
    hi_ext   = tgt_ext + db_ext;
    slow     = meas_ext < lo_ext;
    fast     = meas_ext > hi_ext;
    rev_up   = (dir_q == DIR_DN);
    rev_dn   = (dir_q == DIR_UP);
    step_up  = (tracking_q || rev_up) ? STEP_ONE : STEP_COARSE;
    step_dn  = (tracking_q || rev_dn) ? STEP_ONE : STEP_COARSE;
    up_sum   = {1'b0, code_q} + step_up;
    code_up  = (up_sum > {1'b0, CODE_MAX}) ? CODE_MAX : up_sum[CODE_BITS-1:0];
    code_dn  = ({1'b0, code_q} < step_dn) ? '0 : code_q - step_dn[CODE_BITS-1:0];
  end

  // Decision is taken on the closing edge so the pulse and the new code
  // appear together in the following cycle.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    dco_cnt_d  = dco_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    code_d     = code_q;
    up_d       = 1'b0;
    dn_d       = 1'b0;
    tracking_d = tracking_q;
    if (!enable) begin
      state_d    = ST_IDLE;
      dco_cnt_d  = '0;
      ref_cnt_d  = '0;
      tracking_d = 1'b0;
      dir_d      = DIR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (refEdge) begin
            state_d   = ST_COUNT;
            dco_cnt_d = '0;
            ref_cnt_d = '0;
          end
        end
        ST_COUNT: begin
          dco_cnt_d = dco_inc;
          if (refEdge) begin
            if (ref_cnt_q == REF_LAST) begin
              dco_cnt_d = '0;
              ref_cnt_d = '0;
              if (slow) begin
                tracking_d = tracking_q | rev_up;
                code_d     = code_up;
                up_d       = (code_q != CODE_MAX);
                dir_d      = DIR_UP;
              end else if (fast) begin
                tracking_d = tracking_q | rev_dn;
                code_d     = code_dn;
                dn_d       = (code_q != '0);
                dir_d      = DIR_DN;
              end else begin
                tracking_d = 1'b1;
              end
            end else begin
              ref_cnt_d = ref_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_NONE;
      dco_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      code_q     <= CODE_RST;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      tracking_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      dco_cnt_q  <= dco_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      code_q     <= code_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      tracking_q <= tracking_d;
    end
  end

  assign freqUp   = up_q;
  assign freqDn   = dn_q;
  assign freqCode = code_q;
  assign tracking = tracking_q;

endmodule

// File: tb/tb_freq_track_ctrl.sv
// Bench for freq_track_ctrl: directed vector table, hand sequences and random
// reference timing, checked every cycle against an edge-timestamp model.
module tb_freq_track_ctrl;

  logic        clk, rst, enable, ref_edge;
  logic [11:0] target;
  logic [2:0]  deadband;
  logic        up_a, dn_a, trk_a, up_b, dn_b, trk_b;
  logic [7:0]  code_a, code_b;

  freq_track_ctrl dut_a (
    .clock(clk), .reset(rst), .enable(enable), .refEdge(ref_edge),
    .target(target), .deadband(deadband),
    .freqUp(up_a), .freqDn(dn_a), .freqCode(code_a), .tracking(trk_a)
  );

  freq_track_ctrl #(.CODE_INIT(253)) dut_b (
    .clock(clk), .reset(rst), .enable(enable), .refEdge(ref_edge),
    .target(target), .deadband(deadband),
    .freqUp(up_b), .freqDn(dn_b), .freqCode(code_b), .tracking(trk_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: windows are measured as the cycle distance between reference edges.
  typedef struct {
    int st;      // 0 idle, 1 waiting for first edge, 2 measuring
    int start;
    int n;
    int code;
    bit trk;
    int dir;     // -1 down, 0 none, +1 up
    bit up;
    bit dn;
  } mdl_t;

  mdl_t m_a, m_b;
  logic [7:0] exp_q[$];

  function automatic mdl_t mdl_reset(input int init);
    mdl_t m;
    m.st = 0; m.start = 0; m.n = 0; m.code = init;
    m.trk = 0; m.dir = 0; m.up = 0; m.dn = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input logic en, input logic edg,
                                    input int tgt, input int db, input int now);
    mdl_t m;
    int len, meas, lo, hi, want, step, nc;
    m = mi;
    m.up = 0;
    m.dn = 0;
    if (!en) begin
      m.st = 0; m.trk = 0; m.dir = 0;
      return m;
    end
    if (m.st == 0) begin
      m.st = 1;
    end else if (m.st == 1) begin
      if (edg) begin m.st = 2; m.start = now; m.n = 0; end
    end else if (edg) begin
      m.n++;
      if (m.n == 4) begin
        len = now - m.start;
        meas = (len > 4095) ? 4095 : len;
        m.start = now;
        m.n = 0;
        lo = (tgt > db) ? tgt - db : 0;
        hi = tgt + db;
        want = (meas < lo) ? 1 : ((meas > hi) ? -1 : 0);
        if (want == 0) begin
          m.trk = 1;
        end else begin
          if (m.dir == -want) m.trk = 1;
          step = m.trk ? 1 : 4;
          nc = m.code + want * step;
          if (nc > 255) nc = 255;
          if (nc < 0) nc = 0;
          m.up = (want == 1) && (nc != m.code);
          m.dn = (want == -1) && (nc != m.code);
          m.code = nc;
          m.dir = want;
        end
      end
    end
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a = mdl_reset(128);
      m_b = mdl_reset(253);
      exp_q.delete();
    end else begin
      m_a = mdl_step(m_a, enable, ref_edge, int'(target), int'(deadband), cyc);
      m_b = mdl_step(m_b, enable, ref_edge, int'(target), int'(deadband), cyc);
      if (m_a.up || m_a.dn) exp_q.push_back(m_a.code[7:0]);
    end
    cyc++;
  end

  task automatic expect_val(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic u, input logic d, input logic t,
                           input logic [7:0] c, input mdl_t m);
    n_chk++;
    if (u !== m.up || d !== m.dn || t !== m.trk || int'(c) != m.code) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got up=%b dn=%b trk=%b code=%0d exp up=%b dn=%b trk=%b code=%0d",
               nm, cyc, u, d, t, c, m.up, m.dn, m.trk, m.code);
    end
  endtask

  // scoreboard: every pulse must carry the next expected code
  always @(negedge clk) begin
    check_out("cycle_a", up_a, dn_a, trk_a, code_a, m_a);
    check_out("cycle_b", up_b, dn_b, trk_b, code_b, m_b);
    if (up_a || dn_a) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_sb unexpected pulse got code=%0d exp none", code_a);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (code_a !== e) begin
          n_fail++;
          $display("FAIL pulse_sb got code=%0d exp=%0d", code_a, e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_edges(input int period, input int n);
    for (int k = 0; k < n; k++) begin
      ref_edge = 1'b1;
      @(negedge clk);
      ref_edge = 1'b0;
      repeat (period - 1) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    expect_val("rst_code_a", int'(code_a), 128);
    expect_val("rst_code_b", int'(code_b), 253);
    expect_val("rst_flags", int'({up_a, dn_a, trk_a, up_b, dn_b, trk_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    bit rst;
    int period;
    int edges;
    int tgt;
    int db;
    int exp_a;
    bit trk_a;
    int exp_b;
    bit trk_b;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst = 1'b1; enable = 1'b0; ref_edge = 1'b0; target = 12'd400; deadband = 3'd2;
    //        rst per edg  tgt  db  code_a trk_a code_b trk_b
    tbl[0]  = '{1, 90,   13, 400, 2, 140, 0, 255, 0};
    tbl[1]  = '{1, 90,    9, 400, 2, 136, 0, 255, 0};
    tbl[2]  = '{0, 105,   4, 400, 2, 135, 1, 254, 1};
    tbl[3]  = '{0, 105,   4, 400, 2, 134, 1, 253, 1};
    tbl[4]  = '{1, 100,   5, 400, 2, 128, 1, 253, 1};
    tbl[5]  = '{0, 99,    4, 400, 2, 129, 1, 254, 1};
    tbl[6]  = '{0, 100,   4, 401, 2, 129, 1, 254, 1};
    tbl[7]  = '{0, 100,   4, 398, 2, 129, 1, 254, 1};
    tbl[8]  = '{0, 100,   4, 397, 2, 128, 1, 253, 1};
    tbl[9]  = '{0, 2,     4, 1,   5, 127, 1, 252, 1};
    tbl[10] = '{0, 1,     4, 2,   5, 127, 1, 252, 1};
    tbl[11] = '{1, 1100,  5, 400, 2, 124, 0, 249, 0};
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      target = 12'(tbl[i].tgt);
      deadband = 3'(tbl[i].db);
      if (tbl[i].rst) do_reset();
      drive_edges(tbl[i].period, tbl[i].edges);
      expect_val($sformatf("tbl%0d_code_a", i), int'(code_a), tbl[i].exp_a);
      expect_val($sformatf("tbl%0d_trk_a", i), int'(trk_a), int'(tbl[i].trk_a));
      expect_val($sformatf("tbl%0d_code_b", i), int'(code_b), tbl[i].exp_b);
      expect_val($sformatf("tbl%0d_trk_b", i), int'(trk_b), int'(tbl[i].trk_b));
    end

    // enable dropped mid-window: code held, then a fresh five-edge acquisition
    target = 12'd400;
    deadband = 3'd2;
    repeat (50) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    expect_val("hold_code_a", int'(code_a), 124);
    expect_val("hold_code_b", int'(code_b), 249);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    drive_edges(90, 4);
    expect_val("no_eval_4_edges", int'(code_a), 124);
    drive_edges(90, 1);
    expect_val("reeval_code_a", int'(code_a), 128);
    expect_val("reeval_code_b", int'(code_b), 253);
    expect_val("reeval_trk", int'(trk_a), 0);

    // random reference timing, targets and enable drops
    for (int w = 0; w < 160; w++) begin
      if ($urandom_range(0, 19) == 0) begin
        target = 12'($urandom_range(300, 500));
        deadband = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 29) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        enable = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) drive_edges(1, 1);
      else drive_edges(int'($urandom_range(80, 120)), 1);
    end
    repeat (3) @(negedge clk);
    expect_val("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_track_ctrl.md
Name: freq_track_ctrl

Overview:
- Digital frequency-acquisition controller for the PLL.
- Counts DCO-divided clock cycles across a window of reference edges and compares the count to a target. Steps the DCO frequency code up or down.
- Emits one-cycle freqUp/freqDn pulses. These are the events the lock detector counts.
- Coarse steps during acquisition, then unit steps once tracking.

Parameters:
- CODE_BITS, 8, width of DCO frequency code
- COUNT_BITS, 12, width of DCO cycle counter, target and deadband compare
- WIN_BITS, 2, window length = 2^WIN_BITS reference periods
- COARSE_STEP, 4, code step in acquire mode
- CODE_INIT, 128, freqCode reset value

Ports:
- clock  input  1  DCO-divided clock; the only clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  run control; low idles the block, code holds
- refEdge  input  1  single-cycle pulse marking a reference rising edge, already synchronized to clock
- target  input  COUNT_BITS  expected clock cycles per window
- deadband  input  3  allowed |measured-target| with no correction
- freqUp  output  1  one-cycle pulse: code incremented
- freqDn  output  1  one-cycle pulse: code decremented
- freqCode  output  CODE_BITS  DCO frequency code
- tracking  output  1  high when in fine (unit-step) mode

Behaviour:
- Reset (async, high): state IDLE, freqCode=CODE_INIT, freqUp=freqDn=0, tracking=0, counters 0, lastDir=none.
- States:
  - IDLE: enable=1 -> ARM; refEdge ignored.
  - ARM: first refEdge -> COUNT. That edge is the window start; dcoCount=0, refCount=0.
  - COUNT: dcoCount +1 per cycle, saturating at all-ones. refCount +1 on each refEdge.
  - Window close: refEdge while refCount==2^WIN_BITS-1.
    - measured <= sat(dcoCount+1), i.e. cycles between start and closing edge.
    - dcoCount<=0, refCount<=0. The closing edge starts the next window.
    - evalPending<=1.
- Eval, cycle after closing edge (counting continues):
  - Compares at COUNT_BITS+2 width; no wrap.
  - measured < target-deadband: DCO slow, up.
  - measured > target+deadband: DCO fast, down.
  - Otherwise: in band, no pulse.
  - step = tracking ? 1 : COARSE_STEP.
  - up: freqCode<=min(code+step, 2^CODE_BITS-1). Down: freqCode<=max(code-step, 0).
- Pulses:
  - freqUp/freqDn registered. Asserted in the same cycle freqCode shows the new value.
  - Exactly one cycle wide; never both high.
  - Pulse suppressed if code is already at the rail in that direction (code unchanged).
  - Partial move to rail (e.g. 253+4 -> 255) does pulse.
- Tracking mode:
  - Set on the first in-band window, or on a direction reversal vs lastDir (up after down or down after up).
  - The reversal step itself already uses unit step.
  - Cleared only by reset or enable=0.
- enable=0 in any state:
  - Next cycle: IDLE, counters cleared, pending eval discarded, no pulse, tracking=0, lastDir=none.
  - freqCode holds.
- refEdge in the eval cycle counts normally toward the new window.
- Saturated dcoCount (measured=all-ones) behaves as fast -> down.
- target < deadband: lower bound clamps at 0, so measured can never be slow.
- Latency: closing refEdge at cycle t -> pulse and code update visible at t+1.

Test Plan (CODE_BITS=8, COUNT_BITS=12, WIN_BITS=2, COARSE_STEP=4, target=400, deadband=2):
- Reset asserted mid-run -> freqCode=128 immediately; freqUp=freqDn=tracking=0; no pulse after release until enable plus 5 refEdges.
- enable=1, refEdge every 90 clocks (window 360) -> freqUp one cycle after 5th, 9th, 13th edge; freqCode 128->132->136->140; tracking=0.
- Window 420 after two up windows -> freqDn; code 136->135 with unit step (reversal); tracking=1; next 420 window -> 134.
- Window 401 from reset -> no pulse, tracking=1. Then window 396 -> freqUp, code +1. Window 398 -> no pulse.
- CODE_INIT=253, window 360 -> code 255 with freqUp; next slow window -> no pulse, code 255. Window 0-padded to max count -> freqDn.
- enable dropped 50 clocks into a window -> no pulse, code held. Re-enable -> ARM; first refEdge starts window; eval after 4 further edges.
